// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, types and helpers for the 8-digit multiplexed
// 7-segment calendar/time display.
//   - field codes for the edit selector (SEL_*)
//   - page encoding (PAGE_TIME / PAGE_DATE)
//   - active-high segment patterns {g,f,e,d,c,b,a}
//   - frame_t: one scan frame's snapshot of the counter fields + selector
package seg7_pkg;

  localparam logic [2:0] SEL_SS   = 3'd0;
  localparam logic [2:0] SEL_MM   = 3'd1;
  localparam logic [2:0] SEL_HH   = 3'd2;
  localparam logic [2:0] SEL_DD   = 3'd3;
  localparam logic [2:0] SEL_MO   = 3'd4;
  localparam logic [2:0] SEL_YYYY = 3'd5;
  localparam logic [2:0] SEL_NONE = 3'd6;  // 7 is also treated as "none"

  typedef enum logic {
    PAGE_TIME = 1'b0,
    PAGE_DATE = 1'b1
  } page_e;

  localparam logic [6:0] SEG_DASH  = 7'b1000000;  // g only
  localparam logic [6:0] SEG_E     = 7'b1111001;  // a,d,e,f,g
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic [7:0]  ss;
    logic [7:0]  mm;
    logic [7:0]  hh;
    logic [7:0]  dd;
    logic [7:0]  mo;
    logic [15:0] yyyy;
    logic [2:0]  sel;
  } frame_t;

  // Selector names a field that lives on the time page.
  function automatic logic is_time_field(input logic [2:0] sel);
    return sel <= SEL_HH;
  endfunction

  // Selector names any editable field (anything else is run mode).
  function automatic logic is_edit_field(input logic [2:0] sel);
    return sel <= SEL_YYYY;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational nibble -> active-high segment pattern.
//   nib_i [3:0] : BCD digit; 10..15 show 'E' so a corrupted counter is visible
//   seg_o [6:0] : {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (nib_i)
      4'd0: seg_o = 7'b0111111;
      4'd1: seg_o = 7'b0000110;
      4'd2: seg_o = 7'b1011011;
      4'd3: seg_o = 7'b1001111;
      4'd4: seg_o = 7'b1100110;
      4'd5: seg_o = 7'b1101101;
      4'd6: seg_o = 7'b1111101;
      4'd7: seg_o = 7'b0000111;
      4'd8: seg_o = 7'b1111111;
      4'd9: seg_o = 7'b1101111;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexes the calendar counter onto an 8-digit
// 7-segment display. Page 0 = "HH-MM-SS", page 1 = "DD.MO.YYYY". The field
// under edit blinks. Inputs are snapshotted once per scan frame.
//   clk, rst_n        : system clock, async active-low reset
//   bcd_*             : packed-BCD counter fields
//   select_item [2:0] : 0..5 edit field, 6/7 run mode
//   page_toggle       : 1-cycle pulse, flips page in run mode
//   an  [7:0]         : one-hot digit enable (bit 7 = leftmost)
//   seg [6:0]         : {g,f,e,d,c,b,a}
//   dp                : decimal point
// Outputs are registered; ACTIVE_LOW selects common-anode polarity.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bcd_ss,
  input  logic [7:0]  bcd_mm,
  input  logic [7:0]  bcd_hh,
  input  logic [7:0]  bcd_dd,
  input  logic [7:0]  bcd_mo,
  input  logic [15:0] bcd_yyyy,
  input  logic [2:0]  select_item,
  input  logic        page_toggle,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int DIG_DIV = CLK_HZ / SCAN_HZ;
  localparam int BLK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int DW      = (DIG_DIV > 1) ? $clog2(DIG_DIV) : 1;
  localparam int BW      = (BLK_DIV > 1) ? $clog2(BLK_DIV) : 1;
  localparam logic [DW-1:0] DIG_LAST = DW'(DIG_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLK_DIV - 1);

  // Inactive levels of the output pins.
  localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [DW-1:0] dig_cnt_q, dig_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  page_e         page_q, page_d;
  frame_t        frame_q, frame_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [3:0]    nib;
  logic          is_dash;
  logic          dp_on;
  logic [2:0]    own_field;
  logic          blank;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_raw;

  // ---------------------------------------------------------------- timing
  always_comb begin
    tick      = (dig_cnt_q == DIG_LAST);
    dig_cnt_d = tick ? '0 : dig_cnt_q + DW'(1);
    idx_d     = tick ? idx_q + 3'd1 : idx_q;

    blk_cnt_d = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + BW'(1);
    phase_d   = (blk_cnt_q == BLK_LAST) ? ~phase_q : phase_q;

    // Latch a whole frame at the wrap from digit 7 to digit 0 so a counter
    // update never shows half-old/half-new digits.
    frame_d = frame_q;
    if (tick && idx_q == 3'd7) begin
      frame_d.ss   = bcd_ss;
      frame_d.mm   = bcd_mm;
      frame_d.hh   = bcd_hh;
      frame_d.dd   = bcd_dd;
      frame_d.mo   = bcd_mo;
      frame_d.yyyy = bcd_yyyy;
      frame_d.sel  = select_item;
    end

    // Editing pins the page that holds the field; only run mode honours the
    // toggle, and it acts immediately rather than at frame start.
    page_d = page_q;
    if (is_time_field(frame_q.sel))      page_d = PAGE_TIME;
    else if (is_edit_field(frame_q.sel)) page_d = PAGE_DATE;
    else if (page_toggle)                page_d = page_e'(~page_q);
  end

  // ------------------------------------------------------------ digit map
  always_comb begin
    nib       = 4'h0;
    is_dash   = 1'b0;
    dp_on     = 1'b0;
    own_field = SEL_NONE;
    if (page_q == PAGE_TIME) begin
      case (idx_q)
        3'd7: begin nib = frame_q.hh[7:4]; own_field = SEL_HH; end
        3'd6: begin nib = frame_q.hh[3:0]; own_field = SEL_HH; end
        3'd5: is_dash = 1'b1;
        3'd4: begin nib = frame_q.mm[7:4]; own_field = SEL_MM; end
        3'd3: begin nib = frame_q.mm[3:0]; own_field = SEL_MM; end
        3'd2: is_dash = 1'b1;
        3'd1: begin nib = frame_q.ss[7:4]; own_field = SEL_SS; end
        default: begin nib = frame_q.ss[3:0]; own_field = SEL_SS; end
      endcase
    end else begin
      case (idx_q)
        3'd7: begin nib = frame_q.dd[7:4]; own_field = SEL_DD; end
        3'd6: begin nib = frame_q.dd[3:0]; own_field = SEL_DD; dp_on = 1'b1; end
        3'd5: begin nib = frame_q.mo[7:4]; own_field = SEL_MO; end
        3'd4: begin nib = frame_q.mo[3:0]; own_field = SEL_MO; dp_on = 1'b1; end
        3'd3: begin nib = frame_q.yyyy[15:12]; own_field = SEL_YYYY; end
        3'd2: begin nib = frame_q.yyyy[11:8];  own_field = SEL_YYYY; end
        3'd1: begin nib = frame_q.yyyy[7:4];   own_field = SEL_YYYY; end
        default: begin nib = frame_q.yyyy[3:0]; own_field = SEL_YYYY; end
      endcase
    end
  end

  bcd_to_seg7 u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  // Blanking drops segments/dp only; the anode stays on so the scan is
  // uninterrupted. Dash digits own SEL_NONE and so never match an edit code.
  always_comb begin
    blank   = ~phase_q && is_edit_field(frame_q.sel) && (own_field == frame_q.sel);
    seg_raw = blank ? SEG_BLANK : (is_dash ? SEG_DASH : dec_seg);
    an_d    = ACTIVE_LOW ? ~(8'h01 << idx_q) : (8'h01 << idx_q);
    seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d    = ACTIVE_LOW ? ~(dp_on & ~blank) : (dp_on & ~blank);
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_cnt_q <= '0;
      blk_cnt_q <= '0;
      idx_q     <= '0;
      phase_q   <= 1'b1;
      page_q    <= PAGE_TIME;
      frame_q   <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= DP_OFF;
    end else begin
      dig_cnt_q <= dig_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      page_q    <= page_d;
      frame_q   <= frame_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bcd_ss = 8'h00, bcd_mm = 8'h00, bcd_hh = 8'h00;
  logic [7:0]  bcd_dd = 8'h00, bcd_mo = 8'h00;
  logic [15:0] bcd_yyyy = 16'h0000;
  logic [2:0]  select_item = 3'd7;
  logic        page_toggle = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] cap_seg [8];
  logic       cap_dp  [8];

  // Active-low segment patterns (common anode), {g,f,e,d,c,b,a}
  localparam logic [6:0] L0 = 7'h40, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19;
  localparam logic [6:0] L5 = 7'h12, L8 = 7'h00, L9 = 7'h10;
  localparam logic [6:0] LE = 7'h06, LDASH = 7'h3F, LBLANK = 7'h7F;

  seg7_scan_display #(
    .CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bcd_ss(bcd_ss), .bcd_mm(bcd_mm), .bcd_hh(bcd_hh),
    .bcd_dd(bcd_dd), .bcd_mo(bcd_mo), .bcd_yyyy(bcd_yyyy),
    .select_item(select_item), .page_toggle(page_toggle),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Advance on negedges until digit d is enabled; bounded.
  task automatic wait_digit(input int d);
    logic [7:0] pat;
    bit found;
    pat = ~(8'h01 << d);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (an === pat) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      vectors++; miscompares++;
      $display("FAIL wait_digit%0d: an=%h, expected %h", d, an, pat);
    end
  endtask

  task automatic sync_frame();
    wait_digit(7);
    wait_digit(0);
  endtask

  task automatic capture_frame();
    for (int d = 0; d < 8; d++) begin
      wait_digit(d);
      cap_seg[d] = seg;
      cap_dp[d]  = dp;
    end
  endtask

  task automatic pulse_toggle();
    @(negedge clk); page_toggle = 1'b1;
    @(negedge clk); page_toggle = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (an !== 8'hFF) begin miscompares++; $display("FAIL reset_an: got %h, expected ff", an); end
    vectors++; if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg: got %h, expected 7f", seg); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b, expected 1", dp); end
    rst_n = 1'b1;
    // Digit d is enabled after edges 4d+1..4d+4 following release.
    for (int k = 1; k <= 36; k++) begin
      logic [7:0] exp_an;
      @(negedge clk);
      exp_an = ~(8'h01 << (((k - 1) / 4) % 8));
      vectors++;
      if (an !== exp_an) begin
        miscompares++;
        $display("FAIL rotate_c%0d: an=%h, expected %h", k, an, exp_an);
      end
    end
  endtask

  task automatic test_time();
    logic [6:0] exp_seg [8];
    bcd_hh = 8'h23; bcd_mm = 8'h59; bcd_ss = 8'h58; select_item = 3'd7;
    sync_frame(); sync_frame();
    capture_frame();
    exp_seg[7] = L2; exp_seg[6] = L3; exp_seg[5] = LDASH; exp_seg[4] = L5;
    exp_seg[3] = L9; exp_seg[2] = LDASH; exp_seg[1] = L5; exp_seg[0] = L8;
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL time_d%0d: seg=%h dp=%b, expected seg=%h dp=1", d, cap_seg[d], cap_dp[d], exp_seg[d]);
      end
    end
  endtask

  task automatic test_date();
    logic [6:0] exp_seg [8];
    logic       exp_dp  [8];
    bcd_dd = 8'h29; bcd_mo = 8'h02; bcd_yyyy = 16'h2008;
    pulse_toggle();
    sync_frame(); sync_frame();
    capture_frame();
    exp_seg[7] = L2; exp_seg[6] = L9; exp_seg[5] = L0; exp_seg[4] = L2;
    exp_seg[3] = L2; exp_seg[2] = L0; exp_seg[1] = L0; exp_seg[0] = L8;
    for (int d = 0; d < 8; d++) exp_dp[d] = (d == 6 || d == 4) ? 1'b0 : 1'b1;
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== exp_dp[d]) begin
        miscompares++;
        $display("FAIL date_d%0d: seg=%h dp=%b, expected seg=%h dp=%b", d, cap_seg[d], cap_dp[d], exp_seg[d], exp_dp[d]);
      end
    end
  endtask

  // Blink phase is 0 on digits 7,6,3,2 of every frame with these divisors.
  task automatic test_blink();
    logic [6:0] exp_seg [8];
    select_item = 3'd2;
    sync_frame(); sync_frame();
    pulse_toggle();  // must be ignored while editing
    sync_frame();
    capture_frame();
    exp_seg[7] = LBLANK; exp_seg[6] = LBLANK; exp_seg[5] = LDASH; exp_seg[4] = L5;
    exp_seg[3] = L9; exp_seg[2] = LDASH; exp_seg[1] = L5; exp_seg[0] = L8;
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL blink_hh_d%0d: seg=%h dp=%b, expected seg=%h dp=1", d, cap_seg[d], cap_dp[d], exp_seg[d]);
      end
    end
    select_item = 3'd1;
    sync_frame(); sync_frame();
    capture_frame();
    exp_seg[7] = L2; exp_seg[6] = L3; exp_seg[4] = L5; exp_seg[3] = LBLANK;
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (cap_seg[d] !== exp_seg[d]) begin
        miscompares++;
        $display("FAIL blink_mm_d%0d: seg=%h, expected %h", d, cap_seg[d], exp_seg[d]);
      end
    end
  endtask

  task automatic test_snapshot();
    select_item = 3'd7;
    sync_frame(); sync_frame();
    wait_digit(3);
    bcd_ss = 8'h5A; bcd_hh = 8'h24;
    wait_digit(6);
    vectors++; if (seg !== L3) begin miscompares++; $display("FAIL snap_old_hh: seg=%h, expected %h", seg, L3); end
    wait_digit(7);
    wait_digit(0);
    vectors++; if (seg !== LE) begin miscompares++; $display("FAIL snap_new_ss_E: seg=%h, expected %h", seg, LE); end
    wait_digit(6);
    vectors++; if (seg !== L4) begin miscompares++; $display("FAIL snap_new_hh: seg=%h, expected %h", seg, L4); end
  endtask

  task automatic test_reset_midframe();
    logic [6:0] exp_seg [8];
    wait_digit(3);
    rst_n = 1'b0;
    #1;
    vectors++; if (an !== 8'hFF) begin miscompares++; $display("FAIL mid_rst_an: got %h, expected ff", an); end
    vectors++; if (seg !== 7'h7F || dp !== 1'b1) begin miscompares++; $display("FAIL mid_rst_seg: seg=%h dp=%b, expected 7f/1", seg, dp); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (an !== 8'hFE) begin miscompares++; $display("FAIL mid_restart_an: got %h, expected fe", an); end
    capture_frame();
    exp_seg[7] = L0; exp_seg[6] = L0; exp_seg[5] = LDASH; exp_seg[4] = L0;
    exp_seg[3] = L0; exp_seg[2] = LDASH; exp_seg[1] = L0; exp_seg[0] = L0;
    for (int d = 0; d < 8; d++) begin
      vectors++;
      if (cap_seg[d] !== exp_seg[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_empty_d%0d: seg=%h dp=%b, expected seg=%h dp=1", d, cap_seg[d], cap_dp[d], exp_seg[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_time();
    test_date();
    test_blink();
    test_snapshot();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
